// File: rtl/veda_imem.sv
// Instruction memory for the VEDA core: a streaming loader port with an auto-incrementing
// write pointer, and a registered fetch port with one-cycle latency and range checking.
module veda_imem #(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          DEPTH     = 200,
  parameter int unsigned          ADDR_W    = 9,
  parameter logic [DATA_W-1:0]    FILL_WORD = 32'hFC010820
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic [ADDR_W:0]   ld_count,
  output logic              ld_full,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_data,
  output logic              f_valid,
  output logic              f_err
);

  localparam int unsigned     IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LastW  = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W:0]     cnt_q;
  logic                full_q;
  logic                ready_q;
  logic [DATA_W-1:0]   f_data_q;
  logic                f_valid_q;
  logic                f_err_q;
  logic                wr_en;

  // Power-up content; reset deliberately leaves the array untouched.
  logic [DATA_W-1:0]   mem_q [DEPTH] = '{default: FILL_WORD};

  // A restart or a mode switch swallows any ld_valid presented in the same cycle.
  assign wr_en = !rst && !mode && !ld_start && (state_q == StLoad) && ld_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b0;
    end else if (mode) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
    end else if (ld_start) begin
      ptr_q <= ld_base;
      cnt_q <= '0;
      if ({1'b0, ld_base} >= DepthW) begin
        state_q <= StFull;
        full_q  <= 1'b1;
        ready_q <= 1'b0;
      end else begin
        state_q <= StLoad;
        full_q  <= 1'b0;
        ready_q <= 1'b1;
      end
    end else if (wr_en) begin
      ptr_q <= ptr_q + 1'b1;
      cnt_q <= cnt_q + 1'b1;
      if ({1'b0, ptr_q} == LastW) begin
        state_q <= StFull;
        full_q  <= 1'b1;
        ready_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[ptr_q[IdxW-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_data_q  <= '0;
      f_valid_q <= 1'b0;
      f_err_q   <= 1'b0;
    end else if (mode && f_req) begin
      f_valid_q <= 1'b1;
      if ({1'b0, f_addr} >= DepthW) begin
        f_data_q <= FILL_WORD;
        f_err_q  <= 1'b1;
      end else begin
        f_data_q <= mem_q[f_addr[IdxW-1:0]];
        f_err_q  <= 1'b0;
      end
    end else begin
      f_valid_q <= 1'b0;
      f_err_q   <= 1'b0;
    end
  end

  assign ld_ready = ready_q;
  assign ld_count = cnt_q;
  assign ld_full  = full_q;
  assign f_data   = f_data_q;
  assign f_valid  = f_valid_q;
  assign f_err    = f_err_q;

endmodule

// File: tb/tb_veda_imem.sv
// Bench for veda_imem: fetch results go through an expectation queue checked by a monitor;
// loader status is checked directly after each stimulus step.
module tb_veda_imem;

  localparam logic [31:0] Fill = 32'hFC010820;

  logic        clk = 1'b0;
  logic        rst, mode, ld_start, ld_valid, ld_ready, ld_full, f_req, f_valid, f_err;
  logic [8:0]  ld_base, f_addr;
  logic [31:0] ld_data, f_data;
  logic [9:0]  ld_count;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  veda_imem dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .ld_count (ld_count),
    .ld_full  (ld_full),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_data   (f_data),
    .f_valid  (f_valid),
    .f_err    (f_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one fetch cycle and record the response it must produce.
  task automatic fetch(input logic [8:0] a, input logic [31:0] d, input logic e);
    mode   = 1'b1;
    f_req  = 1'b1;
    f_addr = a;
    exp_q.push_back({e, d});
    tick();
    f_req = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    ld_valid = 1'b1;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  // Monitor: every f_valid must match the oldest outstanding expectation.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (f_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_f_valid: got data %h err %b expected no response", f_data, f_err);
        end else begin
          e = exp_q.pop_front();
          chk("f_data", f_data, e[31:0]);
          chk("f_err", {31'b0, f_err}, {31'b0, e[32]});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; mode = 1'b0; ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0;
    ld_data = '0; f_req = 1'b0; f_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("reset_f_valid", {31'b0, f_valid}, 32'd0);
    chk("reset_f_data", f_data, 32'd0);
    chk("reset_ld_count", {22'b0, ld_count}, 32'd0);
    chk("reset_ld_full", {31'b0, ld_full}, 32'd0);
    fetch(9'd5, Fill, 1'b0);
    tick();

    // Load three words at base 0, then fetch them back-to-back.
    mode = 1'b0; ld_start = 1'b1; ld_base = 9'd0;
    tick();
    ld_start = 1'b0;
    chk("ready_after_start", {31'b0, ld_ready}, 32'd1);
    ld_valid = 1'b1;
    ld_data = 32'h23DE0000; tick();
    ld_data = 32'h22CD0000; tick();
    ld_data = 32'h028D6820; tick();
    ld_valid = 1'b0;
    chk("count_three", {22'b0, ld_count}, 32'd3);
    fetch(9'd0, 32'h23DE0000, 1'b0);
    fetch(9'd1, 32'h22CD0000, 1'b0);
    fetch(9'd2, 32'h028D6820, 1'b0);
    chk("ready_in_fetch", {31'b0, ld_ready}, 32'd0);
    chk("count_held", {22'b0, ld_count}, 32'd3);
    tick();

    // Full boundary at base 198.
    mode = 1'b0; ld_start = 1'b1; ld_base = 9'd198;
    tick();
    ld_start = 1'b0;
    push(32'hAAAA0001);
    chk("full_after_one", {31'b0, ld_full}, 32'd0);
    push(32'hAAAA0002);
    chk("full_after_two", {31'b0, ld_full}, 32'd1);
    chk("ready_when_full", {31'b0, ld_ready}, 32'd0);
    push(32'hAAAA0003);
    push(32'hAAAA0004);
    chk("count_at_full", {22'b0, ld_count}, 32'd2);
    fetch(9'd198, 32'hAAAA0001, 1'b0);
    fetch(9'd199, 32'hAAAA0002, 1'b0);
    fetch(9'd0, 32'h23DE0000, 1'b0);
    fetch(9'd300, Fill, 1'b1);
    fetch(9'd197, Fill, 1'b0);
    tick();

    // Out-of-range load base goes straight to FULL.
    mode = 1'b0; ld_start = 1'b1; ld_base = 9'd250;
    tick();
    ld_start = 1'b0;
    chk("oob_base_full", {31'b0, ld_full}, 32'd1);
    chk("oob_base_ready", {31'b0, ld_ready}, 32'd0);

    // Restart mid-load with ld_valid high, then reset mid-load.
    ld_start = 1'b1; ld_base = 9'd10;
    tick();
    ld_start = 1'b0;
    push(32'h11110010);
    push(32'h11110011);
    ld_start = 1'b1; ld_base = 9'd20; ld_valid = 1'b1; ld_data = 32'h99999999;
    tick();
    ld_start = 1'b0; ld_valid = 1'b0;
    chk("restart_count", {22'b0, ld_count}, 32'd0);
    chk("restart_ready", {31'b0, ld_ready}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midload_rst_ready", {31'b0, ld_ready}, 32'd0);
    chk("midload_rst_full", {31'b0, ld_full}, 32'd0);
    fetch(9'd10, 32'h11110010, 1'b0);
    fetch(9'd11, 32'h11110011, 1'b0);
    fetch(9'd12, Fill, 1'b0);
    fetch(9'd20, Fill, 1'b0);
    tick();

    // Mode gating in both directions.
    mode = 1'b0; f_req = 1'b1; f_addr = 9'd10;
    tick();
    f_req = 1'b0;
    chk("fetch_in_load_mode", {31'b0, f_valid}, 32'd0);
    ld_start = 1'b1; ld_base = 9'd30;
    tick();
    ld_start = 1'b0;
    mode = 1'b1; ld_valid = 1'b1; ld_data = 32'h55555555;
    tick();
    chk("idle_after_mode", {31'b0, ld_ready}, 32'd0);
    chk("no_write_count", {22'b0, ld_count}, 32'd0);
    mode = 1'b0;
    tick();
    ld_valid = 1'b0;
    chk("idle_no_write", {22'b0, ld_count}, 32'd0);
    fetch(9'd30, Fill, 1'b0);
    fetch(9'd31, Fill, 1'b0);
    tick();
    tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/veda_imem.md
# veda_imem

Parametrised instruction memory for the VEDA RISC core. It replaces the single-mode instruction store with two ports: a streaming program-loader port (valid/ready, auto-incrementing write pointer) and a registered fetch port with one-cycle latency and out-of-range detection. It sits between the program loader/testbench and the fetch stage of the datapath.

## Interface
- DATA_W, 32, instruction word width
- DEPTH, 200, number of stored words
- ADDR_W, 9, address width; DEPTH <= 2^ADDR_W
- FILL_WORD, 32'hFC010820, power-up content of every word and the data returned on out-of-range fetch

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- mode  in  1  0 = load, 1 = fetch
- ld_start  in  1  pulse: (re)start a load at ld_base
- ld_base  in  ADDR_W  first write address of a load
- ld_valid  in  1  ld_data valid
- ld_ready  out  1  block accepts ld_data this cycle
- ld_data  in  DATA_W  word to write
- ld_count  out  ADDR_W+1  words written since the last ld_start
- ld_full  out  1  write pointer passed DEPTH-1; load stopped
- f_req  in  1  fetch request
- f_addr  in  ADDR_W  fetch address
- f_data  out  DATA_W  fetched word
- f_valid  out  1  f_data updated this cycle
- f_err  out  1  accompanies f_valid; f_addr was >= DEPTH

## Operation
- Memory: DEPTH x DATA_W array, all words FILL_WORD at initialisation. rst does not alter memory contents.
- Load FSM states IDLE, LOAD, FULL.
  - IDLE: ld_ready=0. mode=0 and ld_start=1 -> LOAD; pointer <= ld_base, ld_count <= 0.
  - LOAD: ld_ready=1. ld_valid && ld_ready: mem[pointer] <= ld_data, pointer+1, ld_count+1. Write at pointer = DEPTH-1 -> FULL.
  - ld_base >= DEPTH with ld_start -> FULL immediately; no write.
  - FULL: ld_ready=0, ld_full=1; ld_data discarded. No wrap-around.
  - ld_start in LOAD or FULL restarts: pointer <= ld_base, ld_count <= 0, -> LOAD; any ld_valid in that cycle is discarded.
  - mode=1 in any state -> IDLE next cycle; no write occurs in a cycle where mode=1. ld_count and ld_full hold their values until the next ld_start or rst.
- Fetch: active only when mode=1. f_req=1 samples f_addr. Next cycle f_valid=1 and f_data = mem[f_addr], or FILL_WORD with f_err=1 if f_addr >= DEPTH. Without f_req, f_valid=0 and f_err=0, and f_data holds its last value. f_req with mode=0 is ignored.
- Back-to-back f_req every cycle gives one result per cycle, in order.
- A word written in cycle N is visible to a fetch requested in cycle N+1 or later.

## Timing
- Reset (rst high at an edge): state IDLE, pointer 0, ld_count 0, ld_full 0, ld_ready 0, f_data 0, f_valid 0, f_err 0. Reset takes priority over all inputs.
- ld_ready is a registered function of state. It rises the cycle after ld_start.
- Write latency: 1 edge. ld_count reflects the write on the same edge.
- Fetch latency: exactly 1 cycle, request to f_valid. No backpressure on the fetch port.
- Reset asserted mid-load: the load aborts. Words already written are retained. Reload needs a new ld_start.

## Test plan
- Reset then idle: rst for 2 cycles. Then ld_ready=0, f_valid=0, f_data=0, ld_count=0. A fetch of addr 5 returns 32'hFC010820, f_err=0.
- Load and fetch: ld_start with base 0, then stream 0x23DE0000, 0x22CD0000, 0x028D6820 with ld_valid held. Expect ld_count=3. Switch mode=1 and fetch addr 0,1,2 back-to-back. Expect those words on 3 consecutive f_valid cycles.
- Full boundary: ld_base=198, push 4 words. Expect writes at 198 and 199, ld_full=1 and ld_ready=0 after the 2nd word, ld_count=2, and mem[0] unchanged.
- Out of range: mode=1, fetch f_addr=300. Next cycle f_valid=1, f_err=1, f_data=32'hFC010820.
- Restart and reset: load 2 words at base 10, then ld_start with base 20 while ld_valid=1. Expect no write in the restart cycle and ld_count=0. Then assert rst mid-load. Fetch 10, 11 returns the loaded words, and 20 returns FILL_WORD if no word was accepted there.
- Mode gating: f_req with mode=0 gives f_valid=0. ld_valid with mode=1 gives no write, and the FSM is in IDLE one cycle after mode rises.
